// File: rtl/q4_eval_arbiter.sv
// q4_eval_arbiter
// Two requesters share one A/B evaluation datapath. Each accepted operand pair
// is evaluated in two phases (A|B, then A&B) and the XOR of the phase results
// is returned on the response port together with the owning requester id.
// Optional feature: define Q4_ARB_SELFCHECK_EN to add a sticky chk_err output
// that flags any response disagreeing with the per-lane reference x | ~y.
module q4_eval_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_x,
  input  logic [W-1:0] req0_y,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_x,
  input  logic [W-1:0] req1_y,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_z,
  output logic         rsp_id,
  output logic         busy,
  output logic [15:0]  done_cnt
`ifdef Q4_ARB_SELFCHECK_EN
  ,
  output logic         chk_err
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PH_OR  = 2'd1,
    PH_AND = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [W-1:0]  x_r;
  logic [W-1:0]  y_r;
  logic [W-1:0]  or_r;
  logic [W-1:0]  and_r;
  logic          id_r;
  logic          last_grant_r;
  logic [15:0]   done_cnt_r;

  logic          grant0_s;
  logic          grant1_s;
  logic          hs_s;
  logic          rsp_hs_s;
  logic          win_id_s;
  logic [W-1:0]  win_x_s;
  logic [W-1:0]  win_y_s;
  logic [W-1:0]  a_s;
  logic [W-1:0]  b_s;
  logic [W-1:0]  rsp_z_s;

  // Shared datapath term A = (x^y)&x.
  function automatic logic [W-1:0] eval_a(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x ^ y) & x;
  endfunction

  // Shared datapath term B = ~(x^y).
  function automatic logic [W-1:0] eval_b(input logic [W-1:0] x, input logic [W-1:0] y);
    return ~(x ^ y);
  endfunction

  assign a_s      = eval_a(x_r, y_r);
  assign b_s      = eval_b(x_r, y_r);
  assign rsp_z_s  = or_r ^ and_r;

  // Round-robin grant: only offered in IDLE; on a tie the requester that did not win last goes.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_r == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0_s = last_grant_r;
        grant1_s = ~last_grant_r;
      end else begin
        grant0_s = req0_valid;
        grant1_s = req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Grants are only raised for valid requesters, so a grant is a handshake.
  assign hs_s     = grant0_s | grant1_s;
  assign win_id_s = grant1_s;
  assign win_x_s  = grant1_s ? req1_x : req0_x;
  assign win_y_s  = grant1_s ? req1_y : req0_y;
  assign rsp_hs_s = (state_r == RESP) && rsp_ready;

  // Next-state sequencing IDLE -> PH_OR -> PH_AND -> RESP -> IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_s) begin
          state_s = PH_OR;
        end else begin
          state_s = IDLE;
        end
      end
      PH_OR:  state_s = PH_AND;
      PH_AND: state_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture on handshake and the two evaluation phases on the shared datapath.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      x_r   <= {W{1'b0}};
      y_r   <= {W{1'b0}};
      id_r  <= 1'b0;
      or_r  <= {W{1'b0}};
      and_r <= {W{1'b0}};
    end else begin
      if (hs_s) begin
        x_r  <= win_x_s;
        y_r  <= win_y_s;
        id_r <= win_id_s;
      end
      if (state_r == PH_OR) begin
        or_r <= a_s | b_s;
      end
      if (state_r == PH_AND) begin
        and_r <= a_s & b_s;
      end
    end
  end

  // Round-robin history and the wrapping completion counter.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      last_grant_r <= 1'b1;
      done_cnt_r   <= 16'd0;
    end else begin
      if (hs_s) begin
        last_grant_r <= win_id_s;
      end
      if (rsp_hs_s) begin
        done_cnt_r <= done_cnt_r + 16'd1;
      end
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign rsp_valid  = (state_r == RESP);
  assign busy       = (state_r != IDLE);
  assign rsp_z      = rsp_z_s;
  assign rsp_id     = id_r;
  assign done_cnt   = done_cnt_r;

`ifdef Q4_ARB_SELFCHECK_EN
  logic chk_err_r;

  // Independent per-lane reference for the response value.
  function automatic logic [W-1:0] q4_ref(input logic [W-1:0] x, input logic [W-1:0] y);
    return x | ~y;
  endfunction

  // Sticky flag set when a presented response disagrees with the reference.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      chk_err_r <= 1'b0;
    end else if ((state_r == RESP) && (rsp_z_s != q4_ref(x_r, y_r))) begin
      chk_err_r <= 1'b1;
    end
  end

  assign chk_err = chk_err_r;
`endif

endmodule

// File: tb/tb_q4_eval_arbiter.sv
// Self-checking bench for q4_eval_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model (round-robin winner, fixed
// three-cycle response latency, per-lane result x | ~y).
module tb_q4_eval_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         aresetn;
  logic         req0_valid, req1_valid, rsp_ready;
  logic [W-1:0] req0_x, req0_y, req1_x, req1_y;
  logic         req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [W-1:0] rsp_z;
  logic [15:0]  done_cnt;
`ifdef Q4_ARB_SELFCHECK_EN
  logic         chk_err;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  q4_eval_arbiter #(.W(W)) dut (
    .clk(clk), .aresetn(aresetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_id(rsp_id),
    .busy(busy), .done_cnt(done_cnt)
`ifdef Q4_ARB_SELFCHECK_EN
    , .chk_err(chk_err)
`endif
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_x = 4'd0; req0_y = 4'd0; req1_x = 4'd0; req1_y = 4'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
  endtask

  // Advance negedge by negedge until rsp_valid is seen or the budget runs out.
  task automatic wait_rsp(output bit timed_out);
    int cnt;
    cnt = 0;
    while (!rsp_valid && cnt < 20) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    timed_out = !rsp_valid;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if ({rsp_valid, req0_ready, req1_ready, busy, rsp_id} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 00000", {rsp_valid, req0_ready, req1_ready, busy, rsp_id});
    end
    tests_run++;
    if ({rsp_z, done_cnt} !== 20'h00000) begin
      tests_failed++;
      $display("FAIL reset_values: got z=%h cnt=%h expected 0/0", rsp_z, done_cnt);
    end
`ifdef Q4_ARB_SELFCHECK_EN
    tests_run++;
    if (chk_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_chk_err: got %b expected 0", chk_err);
    end
`endif
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_valid = 1'b1; req0_x = 4'b1010; req0_y = 4'b0110; rsp_ready = 1'b1;
    #1;
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    tests_run++;
    if ({rsp_valid, busy} !== 2'b01) begin
      tests_failed++;
      $display("FAIL single_ph_or: got valid/busy=%b expected 01", {rsp_valid, busy});
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_ph_and: got rsp_valid=%b expected 0", rsp_valid);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if ({rsp_valid, rsp_z, rsp_id} !== {1'b1, 4'b1011, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_resp: got v=%b z=%b id=%b expected v=1 z=1011 id=0", rsp_valid, rsp_z, rsp_id);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if ({rsp_valid, busy, done_cnt} !== {1'b0, 1'b0, 16'd1}) begin
      tests_failed++;
      $display("FAIL single_done: got v=%b busy=%b cnt=%0d expected 0 0 1", rsp_valid, busy, done_cnt);
    end
  endtask

  task automatic test_lanes();
    bit to;
    @(negedge clk);
    req1_valid = 1'b1; req1_x = 4'b0011; req1_y = 4'b0101; rsp_ready = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    wait_rsp(to);
    tests_run++;
    if (to || {rsp_z, rsp_id} !== {4'b1011, 1'b1}) begin
      tests_failed++;
      $display("FAIL lanes_resp: got timeout=%0d z=%b id=%b expected z=1011 id=1", to, rsp_z, rsp_id);
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    bit to;
    logic         exp_id;
    logic [W-1:0] exp_z;
    do_reset();
    req0_valid = 1'b1; req0_x = 4'b1100; req0_y = 4'b1010;
    req1_valid = 1'b1; req1_x = 4'b0001; req1_y = 4'b0111;
    rsp_ready  = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      wait_rsp(to);
      exp_id = k[0];
      exp_z  = exp_id ? (req1_x | ~req1_y) : (req0_x | ~req0_y);
      tests_run++;
      if (to || {rsp_id, rsp_z} !== {exp_id, exp_z}) begin
        tests_failed++;
        $display("FAIL contention_%0d: got timeout=%0d id=%b z=%b expected id=%b z=%b", k, to, rsp_id, rsp_z, exp_id, exp_z);
      end
      @(negedge clk);
      #1;
    end
    drive_idle();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit to;
    logic [W-1:0] hz;
    logic         hid;
    logic [15:0]  hcnt;
    @(negedge clk);
    req0_valid = 1'b1; req0_x = 4'b0100; req0_y = 4'b1100; rsp_ready = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b1; req1_x = 4'b1111; req1_y = 4'b1111;
    #1;
    wait_rsp(to);
    hz = rsp_z; hid = rsp_id; hcnt = done_cnt;
    tests_run++;
    if (to || {hz, hid} !== {4'b0111, 1'b0}) begin
      tests_failed++;
      $display("FAIL bp_first: got timeout=%0d z=%b id=%b expected z=0111 id=0", to, hz, hid);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req0_x = 4'($urandom);
      #1;
      tests_run++;
      if ({rsp_valid, rsp_z, rsp_id, req0_ready, req1_ready, done_cnt} !== {1'b1, hz, hid, 1'b0, 1'b0, hcnt}) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: got v=%b z=%b id=%b rdy=%b%b cnt=%0d expected 1 %b %b 00 %0d",
                 k, rsp_valid, rsp_z, rsp_id, req0_ready, req1_ready, done_cnt, hz, hid, hcnt);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if ({rsp_valid, busy, done_cnt} !== {1'b0, 1'b0, hcnt + 16'd1}) begin
      tests_failed++;
      $display("FAIL bp_release: got v=%b busy=%b cnt=%0d expected 0 0 %0d", rsp_valid, busy, done_cnt, hcnt + 16'd1);
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit to;
    @(negedge clk);
    req1_valid = 1'b1; req1_x = 4'b1001; req1_y = 4'b0011; rsp_ready = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    aresetn = 1'b0;
    #1;
    tests_run++;
    if ({rsp_valid, busy, done_cnt} !== {1'b0, 1'b0, 16'd0}) begin
      tests_failed++;
      $display("FAIL reset_mid_clear: got v=%b busy=%b cnt=%0d expected 0 0 0", rsp_valid, busy, done_cnt);
    end
    @(negedge clk);
    aresetn = 1'b1;
    req0_valid = 1'b1; req0_x = 4'b0010; req0_y = 4'b0010;
    req1_valid = 1'b1; req1_x = 4'b0000; req1_y = 4'b1111;
    #1;
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_mid_grant: got %b expected 10", {req0_ready, req1_ready});
    end
    @(negedge clk);
    drive_idle();
    rsp_ready = 1'b1;
    #1;
    wait_rsp(to);
    tests_run++;
    if (to || {rsp_id, rsp_z} !== {1'b0, 4'b1111}) begin
      tests_failed++;
      $display("FAIL reset_mid_resp: got timeout=%0d id=%b z=%b expected id=0 z=1111", to, rsp_id, rsp_z);
    end
    @(negedge clk);
  endtask

  task automatic test_random(input int n);
    logic         model_last;
    bit           pending;
    int           hs_cyc;
    logic         exp_id;
    logic [W-1:0] exp_z;
    logic [15:0]  exp_done;
    logic         e0, e1;
    do_reset();
    model_last = 1'b1; pending = 1'b0; hs_cyc = 0; exp_done = 16'd0;
    exp_id = 1'b0; exp_z = 4'd0;
    for (int cyc = 0; cyc < n; cyc++) begin
      @(negedge clk);
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_x = 4'($urandom); req0_y = 4'($urandom);
      req1_x = 4'($urandom); req1_y = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      tests_run++;
      if ({busy, done_cnt} !== {pending, exp_done}) begin
        tests_failed++;
        $display("FAIL rand_state cyc %0d: got busy=%b cnt=%0d expected %b %0d", cyc, busy, done_cnt, pending, exp_done);
      end
`ifdef Q4_ARB_SELFCHECK_EN
      tests_run++;
      if (chk_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand_chk_err cyc %0d: got %b expected 0", cyc, chk_err);
      end
`endif
      if (!pending) begin
        e0 = req0_valid && (!req1_valid || model_last);
        e1 = req1_valid && (!req0_valid || !model_last);
        tests_run++;
        if ({req0_ready, req1_ready, rsp_valid} !== {e0, e1, 1'b0}) begin
          tests_failed++;
          $display("FAIL rand_grant cyc %0d: got rdy0/rdy1/v=%b expected %b", cyc,
                   {req0_ready, req1_ready, rsp_valid}, {e0, e1, 1'b0});
        end
        if (e0 || e1) begin
          pending    = 1'b1;
          hs_cyc     = cyc;
          exp_id     = e1;
          exp_z      = e1 ? (req1_x | ~req1_y) : (req0_x | ~req0_y);
          model_last = e1;
        end
      end else begin
        e0 = ((cyc - hs_cyc) >= 3);
        tests_run++;
        if ({req0_ready, req1_ready, rsp_valid} !== {1'b0, 1'b0, e0}) begin
          tests_failed++;
          $display("FAIL rand_busy_io cyc %0d: got rdy0/rdy1/v=%b expected %b", cyc,
                   {req0_ready, req1_ready, rsp_valid}, {1'b0, 1'b0, e0});
        end
        if (e0) begin
          tests_run++;
          if ({rsp_id, rsp_z} !== {exp_id, exp_z}) begin
            tests_failed++;
            $display("FAIL rand_resp cyc %0d: got id=%b z=%b expected id=%b z=%b", cyc, rsp_id, rsp_z, exp_id, exp_z);
          end
          if (rsp_ready) begin
            pending  = 1'b0;
            exp_done = exp_done + 16'd1;
          end
        end
      end
    end
    drive_idle();
    rsp_ready = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_wrap();
    bit to;
    do_reset();
    force dut.done_cnt_r = 16'hFFFF;
    req0_valid = 1'b1; req0_x = 4'b0110; req0_y = 4'b0110; rsp_ready = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    wait_rsp(to);
    release dut.done_cnt_r;
    tests_run++;
    if (to || rsp_z !== 4'b1111) begin
      tests_failed++;
      $display("FAIL wrap_resp: got timeout=%0d z=%b expected z=1111", to, rsp_z);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if ({done_cnt, busy, rsp_valid} !== {16'h0000, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL wrap_count: got cnt=%h busy=%b v=%b expected 0000 0 0", done_cnt, busy, rsp_valid);
    end
`ifdef Q4_ARB_SELFCHECK_EN
    tests_run++;
    if (chk_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_chk_err: got %b expected 0", chk_err);
    end
`endif
  endtask

  initial begin
    aresetn = 1'b0;
    drive_idle();
    test_reset();
    test_single();
    test_lanes();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_random(600);
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/q4_eval_arbiter.md
# q4_eval_arbiter

Shares a single A/B evaluation datapath between two requesters and sequences it over two phases. Phase OR forms A|B and phase AND forms A&B, with both phases computed on the same datapath. The response is their XOR, so the block produces the full q4 function without duplicating the A/B pair. It sits between two operand producers and one result consumer, using valid/ready handshakes on every port.

## Interface
- W, default 4: operand/result width; every operation is bitwise across W lanes.
- clk  input  1  rising-edge clock.
- aresetn  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_ready  output  1  requester 0 pair accepted this cycle.
- req0_x, req0_y  input  W  requester 0 operands.
- req1_valid  input  1  requester 1 has an operand pair.
- req1_ready  output  1  requester 1 pair accepted this cycle.
- req1_x, req1_y  input  W  requester 1 operands.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes the result.
- rsp_z  output  W  result.
- rsp_id  output  1  requester that owns rsp_z.
- busy  output  1  FSM not in IDLE.
- done_cnt  output  16  completed responses; wraps from 0xFFFF to 0.

## Operation
- Datapath functions:
  - A = (x^y)&x.
  - B = ~(x^y).
  - One shared instance of each, fed from operand registers x_r, y_r.
- FSM states: IDLE, PH_OR, PH_AND, RESP.
- IDLE:
  - Arbitrate between the valid requesters; assert ready to the winner only.
  - On a handshake, capture x, y and id into x_r, y_r, id_r, then go to PH_OR.
- PH_OR: or_r <= A|B, then go to PH_AND.
- PH_AND: and_r <= A&B, then go to RESP.
- RESP:
  - rsp_valid=1, rsp_z = or_r^and_r, rsp_id = id_r.
  - When rsp_ready=1: done_cnt increments, then go to IDLE.
  - When rsp_ready=0: rsp_z and rsp_id are held stable.
- Arbitration:
  - Round-robin via last_grant (reset 1, so requester 0 wins the first tie).
  - With one requester valid, it wins.
  - With both valid, the requester != last_grant wins.
  - last_grant updates only on an accepted handshake.
- req*_ready is 0 in every state except IDLE. A requester may drop valid before it is granted; no request is latched without a handshake.
- Reference result per lane: rsp_z = x | ~y.

## Timing
- Reset values:
  - FSM = IDLE.
  - rsp_valid = 0, req0_ready = 0, req1_ready = 0, busy = 0.
  - rsp_z = 0, rsp_id = 0, done_cnt = 0, last_grant = 1.
- ready in IDLE is combinational from req*_valid and last_grant.
- Latency: handshake at edge N, then PH_OR at N+1, PH_AND at N+2, rsp_valid high after edge N+3.
- Throughput with rsp_ready held high: one result per 4 cycles.
- The next handshake can occur in the cycle after the RESP handshake (IDLE).
- Backpressure: RESP is held indefinitely; requesters see ready=0 throughout.
- Reset mid-operation (aresetn low in any state):
  - Asynchronously return to IDLE and clear all outputs.
  - The in-flight request is discarded and done_cnt is not incremented.
- done_cnt wrap: 0xFFFF plus one completion gives 0x0000, with no flag.

## Configuration
- Q4_ARB_SELFCHECK_EN defined:
  - Adds output chk_err (1 bit, reset 0).
  - In RESP, if rsp_z != (x_r | ~y_r), chk_err is set sticky on the next edge.
  - chk_err clears only on reset.
- Q4_ARB_SELFCHECK_EN undefined: chk_err port and its comparison logic are absent; all other behaviour is identical.

## Test plan
- Single request, W=4: req0 x=1010 y=0110 with rsp_ready=1 -> rsp_valid 3 cycles after the handshake, rsp_z=1011, rsp_id=0, done_cnt=1.
- Exhaustive lanes: x=0011 y=0101 -> rsp_z=1011 (lanes 00->1, 01->0, 10->1, 11->1).
- Contention: req0 and req1 both valid continuously after reset -> grants alternate 0,1,0,1 and rsp_id alternates to match.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_z/rsp_id stable, both readys 0, done_cnt unchanged; raise rsp_ready -> one increment, then IDLE.
- Reset mid-operation: assert aresetn low during PH_AND -> rsp_valid=0 immediately, done_cnt=0, next request after release wins as requester 0.
- Counter wrap: preload via 65536 completions (or force) -> done_cnt reads 0x0000 after the 65536th; with Q4_ARB_SELFCHECK_EN defined, chk_err stays 0 throughout.
